// File: rtl/byte_memory_bank.sv
// Word-addressable storage bank: DEPTH words of WIDTH cells, one save port, one registered load port.
// Optional macro WRITE_THROUGH_EN: a same-address save+load returns the new value instead of the old word.
module byte_memory_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             save,
   input  logic             load,
   input  logic [AW-1:0]    address,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             err
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [WIDTH-1:0]            out_q, out_d;
   logic                        vld_q, vld_d;
   logic                        err_q, err_d;
   logic [DEPTH-1:0]            we;
   logic                        in_range;
   logic [WIDTH-1:0]            rd_word;

   // A full power-of-two bank can never see an out-of-range address.
   generate
      if (DEPTH == (1 << AW)) begin : g_full
         assign in_range = 1'b1;
      end else begin : g_part
         assign in_range = (32'(address) < DEPTH);
      end
   endgenerate

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_dec
         assign we[i] = save & in_range & (address == AW'(i));
      end
   endgenerate

   assign rd_word = in_range ? mem_q[address] : '0;

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (we[i]) mem_d[i] = value;
      end
      out_d = '0;
      if (load) begin
`ifdef WRITE_THROUGH_EN
         out_d = (save && in_range) ? value : rd_word;
`else
         out_d = rd_word;
`endif
      end
      vld_d = load;
      err_d = err_q | ((save | load) & ~in_range);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '0;
         out_q <= '0;
         vld_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         out_q <= out_d;
         vld_q <= vld_d;
         err_q <= err_d;
      end
   end

   assign out       = out_q;
   assign out_valid = vld_q;
   assign err       = err_q;

endmodule

// File: doc/byte_memory_bank.md
Name: byte_memory_bank

Overview:
- Addressable word store built from the single-bit save/value memory cell; sits directly downstream of it in the memory progression.
- It is the consumer that groups WIDTH cells into a word and DEPTH words into a bank.
- Provides one write port (save) and one registered read port (load) sharing an address.
- Feeds the register/counter stages that follow in the CPU datapath.

Parameters:
- WIDTH, 8, bits per word.
- DEPTH, 4, number of words. Legal range 2..16.
- AW, 2, address width. Must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- save  input  1  write strobe, sampled on rising clk
- load  input  1  read strobe, sampled on rising clk
- address  input  AW  word select shared by save and load
- value  input  WIDTH  write data
- out  output  WIDTH  registered read data
- out_valid  output  1  high for one cycle when out carries load data
- err  output  1  sticky flag: an access used address >= DEPTH

Behaviour:
- Reset:
  - rst low asynchronously clears every word, out, out_valid and err to 0, regardless of clk.
  - Release is synchronous to the next rising edge: the first edge with rst high may already accept save/load.
- Write:
  - save=1 at edge k with address < DEPTH: mem[address] <= value at edge k.
  - Visible to a load issued at edge k+1 or later.
  - save=0: all words hold (per-bit save/hold identical to the memory cell).
- Read:
  - load=1 at edge k with address < DEPTH: out <= mem[address] at edge k and out_valid=1 for cycle k..k+1.
  - Latency 1 cycle.
  - load=0: out <= 0 and out_valid <= 0. Out is a driven bus, zero when idle.
- Simultaneous save and load, same address:
  - Read-before-write: out returns the old word; mem takes value. (Macro below overrides this.)
- Simultaneous save and load, different addresses: both complete independently in the same cycle.
- Back-to-back loads:
  - out_valid stays high continuously.
  - out updates every cycle.
  - No bubble.
- Out-of-range address (address >= DEPTH, possible when DEPTH is not a power of two):
  - save is ignored, with no word changed.
  - load returns out=0 with out_valid=1.
  - err <= 1 and stays set until reset.
- Value and address are don't-care while both strobes are low.
- Reset asserted mid-operation: any in-flight load is dropped, with out=0 and out_valid=0 immediately.
- No internal FSM beyond the storage array, out register, valid register and err flag.
  - Storage is DEPTH x WIDTH flops with per-word write enable from an address decoder.

Optional Feature:
- Macro WRITE_THROUGH_EN.
- Defined:
  - On simultaneous save and load to the same in-range address, out returns value (the new data), not the old word.
  - Implemented by a bypass mux in front of the out register.
- Undefined: read-before-write as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset:
  - Drive rst=0 mid-cycle with out=0xA5 and out_valid=1.
  - Required: out=0x00, out_valid=0 and err=0 immediately.
  - Then load each address: all read 0x00.
- Write/read sweep:
  - Save 0x11, 0x22, 0x33, 0x44 to addresses 0..3 on consecutive edges.
  - Then 4 back-to-back loads.
  - Required: out sequence 0x11, 0x22, 0x33, 0x44, one cycle after each load, with out_valid high for 4 continuous cycles, then out=0x00 and out_valid=0.
- Collision:
  - mem[2]=0x5A; same edge save=1, load=1, address=2, value=0xC3.
  - Required without macro: out=0x5A.
  - Required with WRITE_THROUGH_EN: out=0xC3.
  - Both builds: a following load of address 2 gives 0xC3.
- Hold:
  - save=0 for 20 cycles with random value and address toggling.
  - Required: loads of all addresses return the prior contents unchanged.
- Out of range (DEPTH=3, AW=2):
  - save 0xFF to address 3.
  - Required: err=1 after the edge, and loads of 0..2 are unchanged.
  - Load of address 3 gives out=0x00 with out_valid=1.
  - err stays 1 until rst=0.
- Parameter sweep:
  - WIDTH=1, DEPTH=2.
  - Required: single-bit write/read matches the memory cell (save 1, load gives 1; save 0, load gives 0).
